// File: rtl/init_frame_pkg.sv
// Shared definitions for the initial-frame generator: FSM states, the 8x8 sprite ROM,
// pattern indices, LFSR taps and the toroidal index helper.
package init_frame_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    localparam logic [2:0] PAT_BLANK   = 3'd0;
    localparam logic [2:0] PAT_BEEHIVE = 3'd1;
    localparam logic [2:0] PAT_TOAD    = 3'd2;
    localparam logic [2:0] PAT_MWSS    = 3'd3;
    localparam logic [2:0] PAT_GLIDER  = 3'd4;
    localparam logic [2:0] PAT_BLINKER = 3'd5;

    // x^32 + x^22 + x^2 + x + 1 for a left-shifting Fibonacci register.
    localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

    // SPRITE[pattern][row]: bit c of each row byte is column c.
    localparam logic [7:0] SPRITE [8][8] = '{
        '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},  // blank
        '{8'h06, 8'h09, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},  // beehive
        '{8'h0E, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},  // toad
        '{8'h04, 8'h11, 8'h20, 8'h21, 8'h3E, 8'h00, 8'h00, 8'h00},  // middleweight spaceship
        '{8'h02, 8'h04, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},  // glider
        '{8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},  // blinker
        '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}
    };

    // (a - b) mod n for 0 <= a < n and 0 <= b < 2n; an offset port is at most
    // 2^clog2(n)-1, so two conditional corrections always suffice.
    function automatic int wrap_diff(input int a, input int b, input int n);
        int d;
        d = a - b;
        if (d < 0) d = d + n;
        if (d < 0) d = d + n;
        return d;
    endfunction

endpackage

// File: rtl/init_frame_gen_lfsr.sv
// Fibonacci LFSR random source with synchronous reseed; a zero load value falls back to SEED.
module lfsr
    import init_frame_pkg::*;
#(
    parameter int           W    = 32,
    parameter logic [W-1:0] TAPS = LFSR_TAPS_32,
    parameter logic [W-1:0] SEED = 32'hACE1_2468
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= SEED;
        end else if (load) begin
            // The all-zero state would lock the register, so it is never loaded.
            q <= (load_val == '0) ? SEED : load_val;
        end else if (en) begin
            q <= {q[W-2:0], ^(q & TAPS)};
        end
    end

endmodule

// File: rtl/init_frame_gen.sv
// Streams one ROWS x COLS initial board, row by row over a valid/ready handshake,
// filled either from an LFSR or from a toroidally placed 8x8 sprite.
module init_frame_gen
    import init_frame_pkg::*;
#(
    parameter int                ROWS   = 16,
    parameter int                COLS   = 16,
    parameter int                LFSR_W = 32,
    parameter logic [LFSR_W-1:0] SEED   = 32'hACE1_2468
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    random,
    input  logic [2:0]              pattern_sel,
    input  logic [$clog2(ROWS)-1:0] row_off,
    input  logic [$clog2(COLS)-1:0] col_off,
    input  logic                    seed_load,
    input  logic [LFSR_W-1:0]       seed_val,
    output logic                    row_valid,
    input  logic                    row_ready,
    output logic [$clog2(ROWS)-1:0] row_idx,
    output logic [COLS-1:0]         row_data,
    output logic                    busy,
    output logic                    done
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    state_t          state;
    logic [RW-1:0]   row_cnt;
    logic            cap_random;
    logic [2:0]      cap_sel;
    logic [RW-1:0]   cap_row_off;
    logic [CW-1:0]   cap_col_off;
    logic [LFSR_W-1:0] lfsr_q;

    logic accept;
    logic lfsr_en;

    assign accept  = row_valid && row_ready;
    assign lfsr_en = (state == IDLE) || accept;
    assign row_idx = row_cnt;

    lfsr #(
        .W    (LFSR_W),
        .TAPS (LFSR_TAPS_32[LFSR_W-1:0]),
        .SEED (SEED)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (seed_load),
        .load_val (seed_val),
        .en       (lfsr_en),
        .q        (lfsr_q)
    );

    // Narrow boards only look at the low LFSR bits; the rest is intentionally unread.
    logic unused_lfsr_bits;
    assign unused_lfsr_bits = ^lfsr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            row_cnt     <= '0;
            cap_random  <= 1'b0;
            cap_sel     <= '0;
            cap_row_off <= '0;
            cap_col_off <= '0;
            row_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cap_random  <= random;
                        cap_sel     <= pattern_sel;
                        cap_row_off <= row_off;
                        cap_col_off <= col_off;
                        row_cnt     <= '0;
                        row_valid   <= 1'b1;
                        busy        <= 1'b1;
                        state       <= STREAM;
                    end
                end
                STREAM: begin
                    if (accept) begin
                        if (row_cnt == RW'(ROWS - 1)) begin
                            row_cnt   <= '0;
                            row_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            row_cnt <= row_cnt + RW'(1);
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    row_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Rows are formed combinationally from the captured request so data appears with row_valid.
    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin : row_gen
        int rr;
        int cc;
        row_data = '0;
        rr = wrap_diff(int'(row_cnt), int'(cap_row_off), ROWS);
        cc = 0;
        if (row_valid) begin
            for (int c = 0; c < COLS; c++) begin
                cc = wrap_diff(c, int'(cap_col_off), COLS);
                if (cap_random) begin
                    row_data[c] = lfsr_q[c % LFSR_W];
                end else if (rr < 8 && cc < 8) begin
                    row_data[c] = SPRITE[cap_sel][rr[2:0]][cc[2:0]];
                end
            end
        end
    end

endmodule

// File: tb/tb_init_frame_gen.sv
// Randomized bench for init_frame_gen against a cycle-level behavioural model of the board rules.
module tb_init_frame_gen;
    import init_frame_pkg::*;

    localparam int          ROWS   = 16;
    localparam int          COLS   = 16;
    localparam int          LFSR_W = 32;
    localparam logic [31:0] SEED   = 32'hACE1_2468;

    logic        clk = 1'b0;
    logic        reset, start, random, seed_load, row_ready;
    logic [2:0]  pattern_sel;
    logic [3:0]  row_off, col_off;
    logic [31:0] seed_val;
    logic        row_valid, busy, done;
    logic [3:0]  row_idx;
    logic [15:0] row_data;

    init_frame_gen #(
        .ROWS(ROWS), .COLS(COLS), .LFSR_W(LFSR_W), .SEED(SEED)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .random(random),
        .pattern_sel(pattern_sel), .row_off(row_off), .col_off(col_off),
        .seed_load(seed_load), .seed_val(seed_val),
        .row_valid(row_valid), .row_ready(row_ready), .row_idx(row_idx),
        .row_data(row_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Behavioural model: a frame in progress, the done cycle, current row, random source, request.
    bit          m_stream, m_done;
    int          m_row;
    logic [31:0] m_lfsr;
    bit          m_rand;
    int          m_sel, m_roff, m_coff;

    logic [15:0] frame [ROWS];

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        logic fb;
        fb = s[31] ^ s[21] ^ s[1] ^ s[0];
        return {s[30:0], fb};
    endfunction

    function automatic bit sprite_cell(input int p, input int r, input int c);
        case (p)
            int'(PAT_BEEHIVE): return ((r == 0 || r == 2) && (c == 1 || c == 2)) ||
                                      (r == 1 && (c == 0 || c == 3));
            int'(PAT_TOAD):    return (r == 0 && c >= 1 && c <= 3) || (r == 1 && c <= 2);
            int'(PAT_MWSS):    return (r == 0 && c == 2) || (r == 1 && (c == 0 || c == 4)) ||
                                      (r == 2 && c == 5) || (r == 3 && (c == 0 || c == 5)) ||
                                      (r == 4 && c >= 1 && c <= 5);
            int'(PAT_GLIDER):  return (r == 0 && c == 1) || (r == 1 && c == 2) ||
                                      (r == 2 && c <= 2);
            int'(PAT_BLINKER): return r == 0 && c <= 2;
            default:           return 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] model_row();
        logic [15:0] v;
        v = '0;
        for (int c = 0; c < COLS; c++) begin
            if (m_rand) begin
                v[c] = m_lfsr[c % LFSR_W];
            end else begin
                int r, k;
                r = ((m_row - m_roff) % ROWS + ROWS) % ROWS;
                k = ((c - m_coff) % COLS + COLS) % COLS;
                v[c] = sprite_cell(m_sel, r, k);
            end
        end
        return v;
    endfunction

    task automatic check_outputs();
        check("row_valid", row_valid, m_stream);
        check("busy", busy, m_stream || m_done);
        check("done", done, m_done);
        check("row_data", row_data, m_stream ? model_row() : 16'h0);
        if (m_stream) check("row_idx", row_idx, m_row);
    endtask

    // Advance the model by the edge about to happen, clock it, then compare.
    task automatic cycle();
        bit idle_now, beat;
        if (reset) begin
            m_stream = 0; m_done = 0; m_row = 0; m_lfsr = SEED;
            m_rand = 0; m_sel = 0; m_roff = 0; m_coff = 0;
        end else begin
            idle_now = !m_stream && !m_done;
            beat     = m_stream && row_ready;
            if (seed_load)            m_lfsr = (seed_val == 0) ? SEED : seed_val;
            else if (idle_now || beat) m_lfsr = lfsr_next(m_lfsr);
            if (m_done) begin
                m_done = 0;
            end else if (idle_now && start) begin
                m_rand = random; m_sel = pattern_sel; m_roff = row_off; m_coff = col_off;
                m_row = 0; m_stream = 1;
            end else if (beat) begin
                if (m_row == ROWS - 1) begin
                    m_stream = 0; m_done = 1;
                end else begin
                    m_row++;
                end
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    // Caller raises start (cycle 1); runs until done, recording accepted rows.
    // ready_mode: 0 always ready, 1 repeating 1,0,0,1, 2 random. glitch pulses start mid-frame.
    task automatic run_frame(input int ready_mode, input bit glitch, output int done_at, output int live);
        int          cyc, accepted;
        bit          prev_stall;
        logic [3:0]  prev_idx;
        logic [15:0] prev_data;
        done_at = -1; live = 0; accepted = 0; prev_stall = 0;
        prev_idx = '0; prev_data = '0;
        for (int r = 0; r < ROWS; r++) frame[r] = '0;
        cycle();
        start = 0; seed_load = 0;
        cyc = 2;
        for (int k = 0; k < 200; k++) begin
            if (prev_stall) begin
                check("stall_idx", row_idx, prev_idx);
                check("stall_data", row_data, prev_data);
            end
            if (done) begin
                done_at = cyc;
                break;
            end
            case (ready_mode)
                0:       row_ready = 1'b1;
                1:       row_ready = (k % 4 == 0) || (k % 4 == 3);
                default: row_ready = 1'($urandom_range(0, 1));
            endcase
            if (row_valid && row_ready) begin
                frame[row_idx] = row_data;
                live += $countones(row_data);
                accepted++;
            end
            prev_stall = row_valid && !row_ready;
            prev_idx   = row_idx;
            prev_data  = row_data;
            if (glitch && row_valid) begin
                start       = 1'($urandom_range(0, 1));
                random      = 1'($urandom_range(0, 1));
                pattern_sel = 3'($urandom_range(0, 7));
                row_off     = 4'($urandom_range(0, 15));
                col_off     = 4'($urandom_range(0, 15));
            end
            cycle();
            start = 0;
            cyc++;
        end
        check("frame_done_seen", done_at > 0, 1'b1);
        check("rows_accepted", accepted, ROWS);
        cycle();
        check("single_done", done, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          done_at, live;
        logic [31:0] exp_lfsr;
        logic [15:0] exp_row;

        reset = 1; start = 0; random = 0; pattern_sel = '0; row_off = '0; col_off = '0;
        seed_load = 0; seed_val = '0; row_ready = 0;
        repeat (3) cycle();
        check("rst_row_idx", row_idx, 4'd0);
        check("rst_row_data", row_data, 16'h0);
        reset = 0;

        // Beehive at (7,6), streamed at full rate.
        start = 1; random = 0; pattern_sel = PAT_BEEHIVE; row_off = 4'd7; col_off = 4'd6; row_ready = 1;
        run_frame(0, 0, done_at, live);
        check("beehive_done_cycle", done_at, ROWS + 2);
        for (int r = 0; r < ROWS; r++) begin
            exp_row = (r == 7 || r == 9) ? 16'h0180 : (r == 8) ? 16'h0240 : 16'h0000;
            check($sformatf("beehive_row%0d", r), frame[r], exp_row);
        end
        check("beehive_live", live, 6);

        // Glider at (15,15) wraps around both edges.
        start = 1; random = 0; pattern_sel = PAT_GLIDER; row_off = 4'd15; col_off = 4'd15;
        run_frame(0, 0, done_at, live);
        check("glider_row0", frame[0], 16'h0002);
        check("glider_row1", frame[1], 16'h8003);
        check("glider_row15", frame[15], 16'h0001);
        check("glider_live", live, 5);

        // Zero seed reloads SEED; the first random row shows its low bits.
        seed_load = 1; seed_val = '0; start = 1; random = 1;
        run_frame(0, 0, done_at, live);
        check("seed_row0", frame[0], SEED[15:0]);
        exp_lfsr = lfsr_next(SEED);
        check("seed_row1", frame[1], exp_lfsr[15:0]);

        // Stall pattern 1,0,0,1 with start pulses that must be ignored.
        start = 1; random = 0; pattern_sel = PAT_MWSS; row_off = 4'd3; col_off = 4'd12;
        run_frame(1, 1, done_at, live);
        check("mwss_live", live, 11);

        // Reset mid-frame at row 5 aborts without a done pulse.
        start = 1; random = 0; pattern_sel = PAT_TOAD; row_off = 4'd2; col_off = 4'd4; row_ready = 1;
        cycle();
        start = 0;
        for (int k = 0; k < 40; k++) begin
            if (row_valid && row_idx == 4'd5) break;
            cycle();
        end
        check("abort_at_row5", row_idx, 4'd5);
        reset = 1;
        cycle();
        check("abort_valid", row_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        reset = 0;
        start = 1; random = 1;
        run_frame(0, 0, done_at, live);
        exp_lfsr = lfsr_next(SEED);
        check("abort_lfsr_reset", frame[0], exp_lfsr[15:0]);

        // Randomized frames with idle gaps, reseeds, stalls and stray starts.
        for (int f = 0; f < 24; f++) begin
            int gap, mode;
            gap = $urandom_range(0, 4);
            for (int g = 0; g < gap; g++) begin
                seed_load = ($urandom_range(0, 3) == 0);
                seed_val  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
                cycle();
            end
            seed_load   = 0;
            mode        = $urandom_range(0, 2);
            random      = 1'($urandom_range(0, 1));
            pattern_sel = 3'($urandom_range(0, 7));
            row_off     = 4'($urandom_range(0, 15));
            col_off     = 4'($urandom_range(0, 15));
            start       = 1;
            run_frame(mode, 1'($urandom_range(0, 1)), done_at, live);
            if (mode == 0) check("rand_done_cycle", done_at, ROWS + 2);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/init_frame_gen.md
INIT_FRAME_GEN -- requirements
Module: init_frame_gen

Interface
REQ-001 Parameter ROWS, default 16: board height in cells; legal range 8..64.
REQ-002 Parameter COLS, default 16: board width in cells; legal range 8..64.
REQ-003 Parameter LFSR_W, default 32: random-source width; fixed maximal-length taps for 32.
REQ-004 Parameter SEED, default 32'hACE1_2468: LFSR reset value; SHALL be nonzero.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle request to generate a frame; sampled only in IDLE.
REQ-008 random  in  1  1 = random fill, 0 = pattern; captured on accepted start.
REQ-009 pattern_sel  in  3  pattern index; captured on accepted start.
REQ-010 row_off  in  $clog2(ROWS)  pattern row origin; captured on accepted start.
REQ-011 col_off  in  $clog2(COLS)  pattern column origin; captured on accepted start.
REQ-012 seed_load  in  1  load seed_val into LFSR this cycle.
REQ-013 seed_val  in  LFSR_W  LFSR load value.
REQ-014 row_valid  out  1  row_data/row_idx are valid.
REQ-015 row_ready  in  1  consumer accepts current row.
REQ-016 row_idx  out  $clog2(ROWS)  index of current row.
REQ-017 row_data  out  COLS  current row; bit c = column c.
REQ-018 busy  out  1  high from accepted start until done.
REQ-019 done  out  1  one-cycle pulse after the last row is accepted.

Function
REQ-020 FSM states SHALL be IDLE, STREAM, DONE.
REQ-021 IDLE with start=1 SHALL capture random/pattern_sel/row_off/col_off, clear row counter, enter STREAM next cycle.
REQ-022 start outside IDLE SHALL be ignored with no effect.
REQ-023 In STREAM, row_valid SHALL be 1; a beat is accepted when row_valid && row_ready.
REQ-024 row_data and row_idx SHALL be held stable while row_valid && !row_ready.
REQ-025 Each accepted beat SHALL increment row_idx by 1; the beat with row_idx=ROWS-1 SHALL move to DONE.
REQ-026 DONE SHALL last exactly one cycle with done=1, row_valid=0, then return to IDLE.
REQ-027 busy SHALL be 1 in STREAM and DONE, 0 in IDLE.
REQ-028 The LFSR SHALL advance one step every cycle in IDLE and on each accepted beat in STREAM, and SHALL hold otherwise.
REQ-029 seed_load SHALL take priority over advance; a seed_val of zero SHALL load SEED instead.
REQ-030 Random mode: row_data[c] = lfsr[c mod LFSR_W] of the current LFSR state.
REQ-031 Pattern mode: cell (r,c) = SPRITE[pattern_sel][(r-row_off) mod ROWS][(c-col_off) mod COLS] when both reduced indices < 8, else 0 (toroidal wrap).
REQ-032 Sprites are 8x8; index 0 blank, 1 beehive, 2 toad, 3 middleweight spaceship, 4 glider, 5 blinker; 6 and 7 blank.
REQ-033 Beehive sprite rows 0..2 SHALL have cells {1,2}, {0,3}, {1,2} set.
REQ-034 Row generation SHALL be combinational from captured state, so row_data is valid in the same cycle row_valid rises (zero added latency); a full frame at row_ready=1 SHALL take ROWS+2 cycles from start to done.

Reset
REQ-035 Reset SHALL force IDLE, LFSR=SEED, row counter=0, captured inputs=0.
REQ-036 During and after reset, row_valid, busy and done SHALL be 0, row_idx 0, and row_data 0.
REQ-037 Reset asserted mid-STREAM SHALL abort the frame with no done pulse.

Structure
REQ-038 Package init_frame_pkg SHALL hold the state enum, SPRITE constant array [8][8][8], pattern index constants, and the LFSR tap constant.
REQ-039 Sub-module lfsr (parameter W, TAPS, SEED; ports clk, reset, load, load_val, en, q) SHALL implement the random source.

Verification
REQ-040 Reset, start with random=0, pattern_sel=1, row_off=7, col_off=6, row_ready=1 -> rows 7 and 9 = bits 7,8; row 8 = bits 6,9; others 0; done at cycle 18.
REQ-041 Pattern 4 with row_off=15, col_off=15 on a 16x16 board -> glider cells wrap to row 0 and column 0; total live cells = 5.
REQ-042 seed_load with seed_val=0, then start with random=1 -> row 0 row_data = SEED[15:0].
REQ-043 row_ready toggling 1,0,0,1 during STREAM -> row_idx and row_data stable in stall cycles, no row skipped or duplicated.
REQ-044 start pulsed while busy=1 -> ignored; captured offsets unchanged; exactly one done.
REQ-045 reset asserted at row_idx=5 -> next cycle row_valid=0, busy=0, no done, LFSR=SEED.
